// File: rtl/wts_sram_access_sequencer.sv
// Timed byte read/write sequencer for an external asynchronous SRAM, with a one-entry pending slot.
// Optional last-read cache enabled by defining WTS_SRAM_READ_CACHE_EN.
module wts_sram_access_sequencer #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [18:0] address,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        drop_err,
  output logic [18:0] sram_a,
  output logic [7:0]  sram_d_out,
  output logic        sram_d_oe,
  input  logic [7:0]  sram_d_in,
  output logic        sram_ncs,
  output logic        sram_noe,
  output logic        sram_nwe
);

  localparam int unsigned MaxSa = (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
  localparam int unsigned MaxCycles = (MaxSa > HOLD_CYCLES) ? MaxSa : HOLD_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic              cur_wr;
  logic              pend_valid;
  logic              pend_wr;
  logic [18:0]       pend_addr;
  logic [7:0]        pend_wdata;

  logic              idle, hold_done, cache_hit;
  logic              start_pend, start_req, launch, store_req, drop, busy_d;
  logic              l_wr;
  logic [18:0]       l_addr;
  logic [7:0]        l_wdata;

`ifdef WTS_SRAM_READ_CACHE_EN
  logic              cache_valid;
  logic [18:0]       cache_addr;
  logic [7:0]        cache_data;
`endif

  always_comb begin
    idle      = (state == StIdle);
    hold_done = (state == StHold) && (cnt == '0);
`ifdef WTS_SRAM_READ_CACHE_EN
    cache_hit = req && !wr && idle && !pend_valid && cache_valid && (address == cache_addr);
`else
    cache_hit = 1'b0;
`endif
    start_pend = pend_valid && (idle || hold_done);
    start_req  = req && idle && !pend_valid && !cache_hit;
    launch     = start_pend || start_req;
    // A req arriving as the pending entry launches refills the freed slot.
    store_req  = req && !start_req && !cache_hit && (!pend_valid || start_pend);
    drop       = req && !start_req && !cache_hit && pend_valid && !start_pend;
    l_wr       = start_pend ? pend_wr    : wr;
    l_addr     = start_pend ? pend_addr  : address;
    l_wdata    = start_pend ? pend_wdata : wdata;
    busy_d     = launch || (!idle && !hold_done) || store_req || (pend_valid && !start_pend);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      cnt         <= '0;
      cur_wr      <= 1'b0;
      pend_valid  <= 1'b0;
      pend_wr     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      busy        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      drop_err    <= 1'b0;
      sram_a      <= '0;
      sram_d_out  <= '0;
      sram_d_oe   <= 1'b0;
      sram_ncs    <= 1'b1;
      sram_noe    <= 1'b1;
      sram_nwe    <= 1'b1;
`ifdef WTS_SRAM_READ_CACHE_EN
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      busy        <= busy_d;
      if (drop) drop_err <= 1'b1;

      if (store_req) begin
        pend_valid <= 1'b1;
        pend_wr    <= wr;
        pend_addr  <= address;
        pend_wdata <= wdata;
      end else if (start_pend) begin
        pend_valid <= 1'b0;
      end

`ifdef WTS_SRAM_READ_CACHE_EN
      if (cache_hit) begin
        rdata       <= cache_data;
        rdata_valid <= 1'b1;
      end
      if (launch && l_wr) cache_valid <= 1'b0;
`endif

      if (launch) begin
        state     <= StSetup;
        cnt       <= CntW'(SETUP_CYCLES - 1);
        cur_wr    <= l_wr;
        sram_a    <= l_addr;
        sram_ncs  <= 1'b0;
        sram_noe  <= 1'b1;
        sram_nwe  <= 1'b1;
        sram_d_oe <= l_wr;
        if (l_wr) sram_d_out <= l_wdata;
      end else begin
        unique case (state)
          StSetup: begin
            if (cnt == '0) begin
              state    <= StAccess;
              cnt      <= CntW'(ACCESS_CYCLES - 1);
              sram_noe <= cur_wr;
              sram_nwe <= !cur_wr;
            end else begin
              cnt <= cnt - CntW'(1);
            end
          end
          StAccess: begin
            if (cnt == '0) begin
              state    <= StHold;
              cnt      <= CntW'(HOLD_CYCLES - 1);
              sram_noe <= 1'b1;
              sram_nwe <= 1'b1;
              if (!cur_wr) begin
                rdata       <= sram_d_in;
                rdata_valid <= 1'b1;
`ifdef WTS_SRAM_READ_CACHE_EN
                cache_valid <= 1'b1;
                cache_addr  <= sram_a;
                cache_data  <= sram_d_in;
`endif
              end
            end else begin
              cnt <= cnt - CntW'(1);
            end
          end
          StHold: begin
            if (cnt == '0) begin
              state     <= StIdle;
              sram_ncs  <= 1'b1;
              sram_d_oe <= 1'b0;
            end else begin
              cnt <= cnt - CntW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wts_sram_access_sequencer.sv
// Scoreboard bench for wts_sram_access_sequencer: expected SRAM cycles and read data are queued
// at issue time and checked by a negedge monitor; cycle-exact strobe checks are directed.
module tb_wts_sram_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [18:0] address;
  logic [7:0]  wdata;
  logic        busy;
  logic [7:0]  rdata;
  logic        rdata_valid, drop_err;
  logic [18:0] sram_a;
  logic [7:0]  sram_d_out, sram_d_in;
  logic        sram_d_oe, sram_ncs, sram_noe, sram_nwe;

  typedef struct packed {
    logic        wr;
    logic [18:0] a;
    logic [7:0]  d;
  } txn_t;

  txn_t       sram_q[$];
  logic [7:0] rd_q[$];
  int         checks = 0;
  int         fails = 0;
  int         txn_cnt = 0;
  logic       prev_noe = 1'b1;
  logic       prev_nwe = 1'b1;

  wts_sram_access_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .wr          (wr),
    .address     (address),
    .wdata       (wdata),
    .busy        (busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .drop_err    (drop_err),
    .sram_a      (sram_a),
    .sram_d_out  (sram_d_out),
    .sram_d_oe   (sram_d_oe),
    .sram_d_in   (sram_d_in),
    .sram_ncs    (sram_ncs),
    .sram_noe    (sram_noe),
    .sram_nwe    (sram_nwe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data or starts a strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (rdata_valid) begin
        if (rd_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL rdata_unexpected: got pulse with rdata=%0h, required no pulse", rdata);
        end else begin
          chk("rdata", rdata, rd_q.pop_front());
        end
      end
      if ((!sram_noe && prev_noe) || (!sram_nwe && prev_nwe)) begin
        txn_cnt++;
        if (sram_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sram_unexpected: got cycle at %0h, required none", sram_a);
        end else begin
          txn_t t;
          t = sram_q.pop_front();
          chk("sram_kind", !sram_nwe, t.wr);
          chk("sram_a", sram_a, t.a);
          chk("sram_ncs_in_strobe", sram_ncs, 0);
          if (t.wr) begin
            chk("sram_d_out", sram_d_out, t.d);
            chk("sram_d_oe_wr", sram_d_oe, 1);
          end
        end
      end
      if (!sram_noe || !sram_nwe) begin
        checks++;
        if ((!sram_noe && !sram_nwe) || (!sram_noe && sram_d_oe)) begin
          fails++;
          $display("FAIL strobe_conflict: got noe=%0b nwe=%0b d_oe=%0b, required exclusive",
                   sram_noe, sram_nwe, sram_d_oe);
        end
      end
    end
    prev_noe = sram_noe;
    prev_nwe = sram_nwe;
  end

  task automatic issue(input logic w, input logic [18:0] a, input logic [7:0] d,
                       input logic push_sram, input logic push_rd, input logic [7:0] exp_rd);
    txn_t t;
    t.wr = w;
    t.a  = a;
    t.d  = d;
    req = 1'b1; wr = w; address = a; wdata = d;
    if (push_sram) sram_q.push_back(t);
    if (push_rd) rd_q.push_back(exp_rd);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || !sram_ncs) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      fails++;
      $display("FAIL %s_timeout: got busy=%0b after 50 cycles, required idle", name, busy);
    end
    @(negedge clk);
  endtask

  initial begin
    int start_cnt;
    reset = 1'b1; req = 1'b0; wr = 1'b0; address = '0; wdata = '0; sram_d_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ncs", sram_ncs, 1);
    chk("rst_noe", sram_noe, 1);
    chk("rst_nwe", sram_nwe, 1);
    chk("rst_d_oe", sram_d_oe, 0);
    chk("rst_a", sram_a, 0);
    chk("rst_d_out", sram_d_out, 0);
    chk("rst_busy_rdata", {busy, rdata_valid, drop_err, rdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read: cycle-exact strobe timing.
    sram_d_in = 8'h5C;
    issue(1'b0, 19'h1A005, 8'h00, 1'b1, 1'b1, 8'h5C);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("rd_ncs_c%0d", c), sram_ncs, (c <= 4) ? 0 : 1);
      chk($sformatf("rd_noe_c%0d", c), sram_noe, (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("rd_valid_c%0d", c), rdata_valid, (c == 4) ? 1 : 0);
      chk($sformatf("rd_busy_c%0d", c), busy, (c <= 4) ? 1 : 0);
      if (c < 5) @(negedge clk);
    end
    wait_idle("read");

    // Single write: data driven across SETUP..HOLD, nwe only during ACCESS.
    issue(1'b1, 19'h7E123, 8'hA5, 1'b1, 1'b0, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("wr_d_oe_c%0d", c), sram_d_oe, (c <= 4) ? 1 : 0);
      if (c <= 4) chk($sformatf("wr_d_out_c%0d", c), sram_d_out, 8'hA5);
      chk($sformatf("wr_nwe_c%0d", c), sram_nwe, (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("wr_noe_c%0d", c), sram_noe, 1);
      if (c < 5) @(negedge clk);
    end
    wait_idle("write");

    // Back-to-back: write held pending, SETUP in cycle 5 with no idle gap.
    sram_d_in = 8'h3C;
    issue(1'b0, 19'h00ABC, 8'h00, 1'b1, 1'b1, 8'h3C);
    @(negedge clk);
    issue(1'b1, 19'h12345, 8'h3E, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("b2b_c4_ncs", sram_ncs, 0);
    chk("b2b_c4_a", sram_a, 19'h00ABC);
    @(negedge clk);
    chk("b2b_c5_ncs", sram_ncs, 0);
    chk("b2b_c5_a", sram_a, 19'h12345);
    chk("b2b_c5_d_oe", sram_d_oe, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_drop_err", drop_err, 0);
    wait_idle("b2b");

    // Overflow: third request dropped, only two SRAM cycles.
    start_cnt = txn_cnt;
    sram_d_in = 8'h77;
    issue(1'b0, 19'h00100, 8'h00, 1'b1, 1'b1, 8'h77);
    @(negedge clk);
    issue(1'b0, 19'h00200, 8'h00, 1'b1, 1'b1, 8'h77);
    issue(1'b1, 19'h00300, 8'h55, 1'b0, 1'b0, 8'h00);
    chk("ovf_drop_err", drop_err, 1);
    wait_idle("ovf");
    repeat (3) @(negedge clk);
    chk("ovf_txn_count", txn_cnt - start_cnt, 2);
    chk("ovf_drop_sticky", drop_err, 1);

    // Reset during read ACCESS with a write pending.
    sram_d_in = 8'hE1;
    issue(1'b0, 19'h05555, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("rst_mid_noe_active", sram_noe, 0);
    issue(1'b1, 19'h06666, 8'h99, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    #1;
    chk("rst_mid_ncs", sram_ncs, 1);
    chk("rst_mid_noe", sram_noe, 1);
    chk("rst_mid_nwe", sram_nwe, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_drop_err", drop_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_post_ncs", sram_ncs, 1);
    chk("rst_post_busy", busy, 0);

`ifdef WTS_SRAM_READ_CACHE_EN
    sram_d_in = 8'h42;
    issue(1'b0, 19'h00010, 8'h00, 1'b1, 1'b1, 8'h42);
    wait_idle("cache_fill");
    sram_d_in = 8'h99;
    issue(1'b0, 19'h00010, 8'h00, 1'b0, 1'b1, 8'h42);
    chk("cache_hit_ncs", sram_ncs, 1);
    chk("cache_hit_busy", busy, 0);
    @(negedge clk);
    issue(1'b1, 19'h00200, 8'h11, 1'b1, 1'b0, 8'h00);
    wait_idle("cache_wr");
    issue(1'b0, 19'h00010, 8'h00, 1'b1, 1'b1, 8'h99);
    chk("cache_miss_ncs", sram_ncs, 0);
    wait_idle("cache_miss");
`endif

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("sram_queue_drained", sram_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule
